// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg -- shared types and the ROM/RAM address map for mem_arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CPU_RD = 2'd1,
        ST_DBG_RD = 2'd2
    } state_t;

    localparam int ROM_AW_DEF = 10;
    localparam int RAM_AW_DEF = 6;
    localparam int REQ_AW     = 10;
    localparam int MEM_AW     = 11;

    // Region select bit placed on top of the shared memory address.
    localparam logic ROM_SEL = 1'b0;
    localparam logic RAM_SEL = 1'b1;

    typedef struct packed {
        logic              rom;
        logic              we;
        logic [REQ_AW-1:0] addr;
        logic [7:0]        wdata;
    } mem_req_t;

    // Region bit on top, offset masked to the region size; RAM upper bits are dropped.
    function automatic logic [MEM_AW-1:0] map_addr(input logic              rom,
                                                   input logic [REQ_AW-1:0] addr,
                                                   input int                rom_aw,
                                                   input int                ram_aw);
        logic [REQ_AW-1:0] off;
        if (rom) begin
            off = addr & REQ_AW'((1 << rom_aw) - 1);
            return {ROM_SEL, off};
        end
        off = addr & REQ_AW'((1 << ram_aw) - 1);
        return {RAM_SEL, off};
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one ROM+RAM memory port between the CPU and a debug port.
// CPU has absolute priority; debug gets the port only in otherwise idle cycles.
// Debug port and stall counter exist only when MEM_ARBITER_DBG_EN is defined;
// otherwise the debug inputs are ignored and the debug outputs read 0.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ROM_AW  = ROM_AW_DEF,
    parameter int RAM_AW  = RAM_AW_DEF,
    parameter int STALL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req,
    input  logic               cpu_rom,
    input  logic               cpu_we,
    input  logic [REQ_AW-1:0]  cpu_addr,
    input  logic [7:0]         cpu_wdata,
    output logic [7:0]         cpu_rdata,
    output logic               cpu_ack,
    input  logic               dbg_valid,
    output logic               dbg_ready,
    input  logic               dbg_rom,
    input  logic               dbg_we,
    input  logic [REQ_AW-1:0]  dbg_addr,
    input  logic [7:0]         dbg_wdata,
    output logic [7:0]         dbg_rdata,
    output logic               dbg_rvalid,
    input  logic               dbg_rom_wp,
    output logic               mem_en,
    output logic               mem_we,
    output logic [MEM_AW-1:0]  mem_addr,
    output logic [7:0]         mem_wdata,
    input  logic [7:0]         mem_rdata,
    output logic [STALL_W-1:0] dbg_stall_cnt
);

    state_t     state, state_nxt;
    logic       cpu_pend, cpu_pend_nxt;
    mem_req_t   pend_req, pend_req_nxt;
    mem_req_t   cpu_live, cpu_sel, grant;
    logic       grant_en;
    logic [7:0] cpu_rdata_q;

    assign cpu_live = '{rom: cpu_rom, we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    // A latched request always goes out before a fresh strobe.
    assign cpu_sel  = cpu_pend ? pend_req : cpu_live;

`ifdef MEM_ARBITER_DBG_EN
    mem_req_t           dbg_live;
    logic               dbg_idle;
    logic [7:0]         dbg_rdata_q;
    logic [STALL_W-1:0] stall_q;

    assign dbg_live = '{rom: dbg_rom, we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
    assign dbg_idle = (state == ST_IDLE) && !cpu_req && !cpu_pend;
`endif

    // State, pending CPU request; reset discards any read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cpu_pend <= 1'b0;
            pend_req <= '0;
        end else begin
            state    <= state_nxt;
            cpu_pend <= cpu_pend_nxt;
            pend_req <= pend_req_nxt;
        end
    end

    // Grant selection, next state and completion strobes; rst silences all strobes.
    always_comb begin
        state_nxt    = state;
        cpu_pend_nxt = cpu_pend;
        pend_req_nxt = pend_req;
        grant        = '0;
        grant_en     = 1'b0;
        cpu_ack      = 1'b0;
        dbg_rvalid   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_pend || cpu_req) begin
                    grant        = cpu_sel;
                    // ROM is read-only to the CPU: the write is acked but never reaches memory.
                    grant_en     = !(cpu_sel.we && cpu_sel.rom);
                    cpu_ack      = cpu_sel.we;
                    state_nxt    = cpu_sel.we ? ST_IDLE : ST_CPU_RD;
                    // A strobe arriving while the pending one issues takes the freed slot.
                    cpu_pend_nxt = cpu_pend && cpu_req;
                    pend_req_nxt = cpu_live;
                end
`ifdef MEM_ARBITER_DBG_EN
                else if (dbg_valid) begin
                    grant     = dbg_live;
                    grant_en  = !(dbg_live.we && dbg_live.rom && dbg_rom_wp);
                    state_nxt = dbg_live.we ? ST_IDLE : ST_DBG_RD;
                end
`endif
            end
            ST_CPU_RD: begin
                cpu_ack   = 1'b1;
                state_nxt = ST_IDLE;
            end
`ifdef MEM_ARBITER_DBG_EN
            ST_DBG_RD: begin
                dbg_rvalid = 1'b1;
                state_nxt  = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
        // Memory is busy returning data: park the CPU strobe for the next cycle.
        if (state != ST_IDLE && cpu_req) begin
            cpu_pend_nxt = 1'b1;
            pend_req_nxt = cpu_live;
        end
        if (rst) begin
            cpu_ack    = 1'b0;
            dbg_rvalid = 1'b0;
            grant_en   = 1'b0;
        end
    end

    assign mem_en    = grant_en;
    assign mem_we    = grant_en & grant.we;
    assign mem_addr  = grant_en ? map_addr(grant.rom, grant.addr, ROM_AW, RAM_AW) : '0;
    assign mem_wdata = grant_en ? grant.wdata : '0;

    // Hold the last CPU read result between acks.
    always_ff @(posedge clk) begin
        if (rst)
            cpu_rdata_q <= '0;
        else if (state == ST_CPU_RD)
            cpu_rdata_q <= mem_rdata;
    end

    assign cpu_rdata = rst ? '0 : (state == ST_CPU_RD) ? mem_rdata : cpu_rdata_q;

`ifdef MEM_ARBITER_DBG_EN
    // Hold the last debug read result between rvalid strobes.
    always_ff @(posedge clk) begin
        if (rst)
            dbg_rdata_q <= '0;
        else if (state == ST_DBG_RD)
            dbg_rdata_q <= mem_rdata;
    end

    // Count cycles the debug master waited on the CPU, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (dbg_valid && !dbg_idle && stall_q != '1)
            stall_q <= stall_q + 1'b1;
    end

    assign dbg_ready     = dbg_idle && !rst;
    assign dbg_rdata     = rst ? '0 : (state == ST_DBG_RD) ? mem_rdata : dbg_rdata_q;
    assign dbg_stall_cnt = rst ? '0 : stall_q;
`else
    logic unused_dbg;
    assign unused_dbg    = ^{dbg_valid, dbg_rom, dbg_we, dbg_addr, dbg_wdata, dbg_rom_wp};
    assign dbg_ready     = 1'b0;
    assign dbg_rdata     = '0;
    assign dbg_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed corner cases plus randomized traffic, checked every
// cycle against a transaction-level reference model of the arbiter and memory.
`timescale 1ns/1ps
module tb_mem_arbiter;

`ifdef MEM_ARBITER_DBG_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_rom, cpu_we;
    logic [9:0]  cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ack;
    logic        dbg_valid, dbg_ready, dbg_rom, dbg_we;
    logic [9:0]  dbg_addr;
    logic [7:0]  dbg_wdata, dbg_rdata;
    logic        dbg_rvalid, dbg_rom_wp;
    logic        mem_en, mem_we;
    logic [10:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [7:0]  dbg_stall_cnt;

    always #5 clk = ~clk;

    mem_arbiter #(.ROM_AW(10), .RAM_AW(6), .STALL_W(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_rom(cpu_rom), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_rom(dbg_rom), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata),
        .dbg_rvalid(dbg_rvalid), .dbg_rom_wp(dbg_rom_wp),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_stall_cnt(dbg_stall_cnt)
    );

    // Physical memory behind the arbiter: read data appears the cycle after mem_en.
    logic [7:0] phys [0:2047];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) phys[mem_addr] <= mem_wdata;
            else        mem_rdata      <= phys[mem_addr];
        end
    end

    // ---------------- reference model ----------------
    typedef struct { bit rom; bit we; int addr; int wdata; } acc_t;

    int   ref_mem [0:2047];
    acc_t cpu_q[$];          // CPU requests waiting for the port
    int   busy;              // 0 free, 1 CPU read returning, 2 debug read returning
    int   busy_data;
    int   last_cpu_rd, last_dbg_rd, stall;
    bit   m_dbg_hs;
    int   n_vec = 0, n_bad = 0;

    function automatic int phys_of(bit rom, int a);
        return rom ? a : 1024 + (a % 64);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Predict and check one cycle at the negedge, then advance to just after the next posedge.
    task automatic step();
        int   e_ack, e_rd, e_en, e_we, e_addr, e_wd, e_rdy, e_rv, e_drd, busy_nxt, pa;
        acc_t g, live;
        bit   have, blocked;
        @(negedge clk);
        {e_ack, e_en, e_we, e_addr, e_wd, e_rdy, e_rv} = '0;
        busy_nxt = 0;
        m_dbg_hs = 1'b0;
        live.rom = cpu_rom; live.we = cpu_we; live.addr = int'(cpu_addr); live.wdata = int'(cpu_wdata);
        if (rst) begin
            busy = 0; cpu_q.delete(); stall = 0; last_cpu_rd = 0; last_dbg_rd = 0;
        end else begin
            have = 1'b0;
            if (busy != 0) begin
                if (busy == 1) begin e_ack = 1; last_cpu_rd = busy_data; end
                else           begin e_rv  = 1; last_dbg_rd = busy_data; end
                if (cpu_req) cpu_q.push_back(live);
            end else begin
                if (cpu_q.size() > 0) begin
                    g = cpu_q.pop_front(); have = 1'b1;
                    if (cpu_req) cpu_q.push_back(live);
                end else if (cpu_req) begin
                    g = live; have = 1'b1;
                end
                if (have) begin
                    pa = phys_of(g.rom, g.addr);
                    blocked = g.we && g.rom;
                    if (!blocked) begin e_en = 1; e_we = g.we; e_addr = pa; e_wd = g.wdata; end
                    if (g.we) begin
                        e_ack = 1;
                        if (!blocked) ref_mem[pa] = g.wdata;
                    end else begin
                        busy_nxt = 1; busy_data = ref_mem[pa];
                    end
                end else if (DBG_EN) begin
                    e_rdy = 1;
                    if (dbg_valid) begin
                        m_dbg_hs = 1'b1;
                        pa = phys_of(dbg_rom, int'(dbg_addr));
                        blocked = dbg_we && dbg_rom && dbg_rom_wp;
                        if (!blocked) begin e_en = 1; e_we = dbg_we; e_addr = pa; e_wd = int'(dbg_wdata); end
                        if (dbg_we) begin
                            if (!blocked) ref_mem[pa] = int'(dbg_wdata);
                        end else begin
                            busy_nxt = 2; busy_data = ref_mem[pa];
                        end
                    end
                end
            end
            if (DBG_EN && dbg_valid && e_rdy == 0 && stall < 255) stall++;
            busy = busy_nxt;
        end
        e_rd  = rst ? 0 : last_cpu_rd;
        e_drd = rst ? 0 : last_dbg_rd;
        chk("cpu_ack",    cpu_ack,       e_ack);
        chk("cpu_rdata",  cpu_rdata,     e_rd);
        chk("mem_en",     mem_en,        e_en);
        chk("mem_we",     mem_we,        e_we);
        chk("mem_addr",   mem_addr,      e_addr);
        chk("mem_wdata",  mem_wdata,     e_wd);
        chk("dbg_ready",  dbg_ready,     e_rdy);
        chk("dbg_rvalid", dbg_rvalid,    e_rv);
        chk("dbg_rdata",  dbg_rdata,     e_drd);
        chk("stall_cnt",  dbg_stall_cnt, stall);
        @(posedge clk); #1;
    endtask

    task automatic idle_in();
        cpu_req = 0; cpu_rom = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_valid = 0; dbg_rom = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic cpu(input bit rom, input bit we, input logic [9:0] a, input logic [7:0] d);
        cpu_req = 1; cpu_rom = rom; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic dbg(input bit rom, input bit we, input logic [9:0] a, input logic [7:0] d);
        dbg_valid = 1; dbg_rom = rom; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    initial begin
        int  orig;
        bit  dbg_took;
        logic [7:0] v;
        for (int i = 0; i < 2048; i++) begin
            v = 8'($urandom);
            phys[i] <= v;
            ref_mem[i] = int'(v);
        end
        busy = 0; stall = 0; last_cpu_rd = 0; last_dbg_rd = 0;
        rst = 1; dbg_rom_wp = 1; idle_in();
        @(posedge clk); #1;
        step(); step();                       // outputs during reset
        rst = 0; step();

        // RAM alias: seed byte 5, then read it back through address 0x3C5
        cpu(0, 1, 10'h005, 8'hA5); step();
        cpu(0, 0, 10'h3C5, 8'h00); step();
        idle_in(); step();
        chk("ram_alias_rd", cpu_rdata, 8'hA5);

        // CPU write to ROM is acked but dropped
        orig = ref_mem[16];
        cpu(1, 1, 10'h010, 8'h55); step();
        cpu(1, 0, 10'h010, 8'h00); step();
        idle_in(); step();
        chk("rom_wr_drop", cpu_rdata, orig);

`ifdef MEM_ARBITER_DBG_EN
        // CPU strobe lands while a debug read is in flight
        dbg(1, 0, 10'h100, 8'h00); step();
        dbg_valid = 0; cpu(0, 0, 10'h3C5, 8'h00); step();
        idle_in(); step(); step();
        chk("dbg_rd_100", dbg_rdata, ref_mem[256]);
`endif

        // Debug starved by a CPU write every cycle
        for (int n = 0; n < 300; n++) begin
            cpu(1'($urandom), 1, 10'($urandom), 8'($urandom));
            dbg(1, 0, 10'h000, 8'h00);
            step();
        end
        chk("stall_sat", dbg_stall_cnt, DBG_EN ? 255 : 0);
        idle_in(); rst = 1; step(); rst = 0; step();

`ifdef MEM_ARBITER_DBG_EN
        // Debug ROM write protection
        orig = ref_mem[1023];
        dbg_rom_wp = 1; dbg(1, 1, 10'h3FF, 8'h77); step();
        dbg(1, 0, 10'h3FF, 8'h00); step();
        idle_in(); step();
        chk("wp_drop", dbg_rdata, orig);
        dbg_rom_wp = 0; dbg(1, 1, 10'h3FF, 8'h77); step();
        dbg(1, 0, 10'h3FF, 8'h00); step();
        idle_in(); step();
        chk("wp_off_wr", dbg_rdata, 8'h77);
`endif

        // Reset while a CPU read is returning
        cpu(0, 0, 10'h005, 8'h00); step();
        idle_in(); rst = 1; step();
        rst = 0; step();
        chk("rst_rd_noack", cpu_ack, 1'b0);

        // Randomized traffic
        dbg_took = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            if (cpu_q.size() == 0 && $urandom_range(0, 99) < 35)
                cpu(1'($urandom), 1'($urandom), 10'($urandom), 8'($urandom));
            else begin
                cpu_req = 0; cpu_rom = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
            end
            if (!dbg_valid || dbg_took) begin
                dbg_valid = 1'($urandom); dbg_rom = 1'($urandom); dbg_we = 1'($urandom);
                dbg_addr = 10'($urandom); dbg_wdata = 8'($urandom);
            end
            dbg_rom_wp = 1'($urandom);
            step();
            dbg_took = m_dbg_hs || rst;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
